// File: rtl/ysyx_23060191_gpr_dump_pkg.sv
// Shared definitions for the GPR dump engine: datapath width, register count
// and the dump FSM state encoding.
package ysyx_23060191_gpr_dump_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int GD_NREG   = 32;

  typedef enum logic [1:0] {
    GD_IDLE  = 2'd0,
    GD_FETCH = 2'd1,
    GD_SEND  = 2'd2,
    GD_DONE  = 2'd3
  } gd_state_e;

endpackage

// File: rtl/ysyx_23060191_gpr_dump.sv
// Walks the GPR read port x0..x31 on a start pulse and streams each value,
// tagged with its index and a last flag, over a valid/ready handshake.
module ysyx_23060191_gpr_dump
  import ysyx_23060191_gpr_dump_pkg::*;
#(
  parameter int NREG   = GD_NREG,
  parameter int DATA_W = CPU_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [4:0]        gpr_raddr,
  input  logic [DATA_W-1:0] gpr_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_idx,
  output logic              out_last
);

  localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

  gd_state_e         state_q;
  logic [4:0]        idx_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [4:0]        out_idx_q;
  logic              out_last_q;
  logic              hs;

  assign hs = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GD_IDLE;
      idx_q       <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= 5'd0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        GD_IDLE: begin
          if (start) begin
            state_q <= GD_FETCH;
            idx_q   <= 5'd0;
          end
        end
        // The GPR answers combinationally, so the value is captured here.
        GD_FETCH: begin
          out_data_q  <= gpr_rdata;
          out_idx_q   <= idx_q;
          out_last_q  <= (idx_q == LAST_IDX);
          out_valid_q <= 1'b1;
          state_q     <= GD_SEND;
        end
        GD_SEND: begin
          if (hs) begin
            out_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q <= GD_DONE;
            end else begin
              idx_q   <= idx_q + 5'd1;
              state_q <= GD_FETCH;
            end
          end
        end
        GD_DONE: begin
          state_q <= GD_IDLE;
          idx_q   <= 5'd0;
        end
        default: state_q <= GD_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != GD_IDLE);
  assign done      = (state_q == GD_DONE);
  assign gpr_raddr = idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_ysyx_23060191_gpr_dump.sv
// Directed bench for the GPR dump engine with a beat scoreboard.
module tb_ysyx_23060191_gpr_dump;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  gpr_raddr;
  logic [31:0] gpr_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;

  logic [31:0] gpr [32];
  beat_t       exp_q [$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  assign gpr_rdata = gpr[gpr_raddr];

  ysyx_23060191_gpr_dump #(.NREG(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .gpr_raddr (gpr_raddr),
    .gpr_rdata (gpr_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  // Drives one full dump from a start sampled in the current cycle (E0) and
  // scores every beat; mode 0 = ready always high, mode 1 = random ready.
  task automatic run_dump(input int mode, input int repulse_at, input bit hold_start);
    int    j, stalls, dones;
    bit    held, fin;
    logic [31:0] hd;
    logic [4:0]  hi;
    logic        hl;
    beat_t       e;
    for (int i = 0; i < 32; i++) exp_q.push_back('{idx: 5'(i), data: gpr[i], last: (i == 31)});
    start = 1'b1;
    out_ready = (mode == 0);
    j = 0; stalls = 0; dones = 0; held = 1'b0; fin = 1'b0;
    hd = '0; hi = '0; hl = 1'b0;
    while (!fin && j < 400) begin
      @(posedge clk); j++;
      @(negedge clk);
      start = hold_start || (j == repulse_at);
      if (j == 1) begin
        chk("fetch_busy", busy, 1);
        chk("fetch_raddr", gpr_raddr, 0);
        chk("fetch_novalid", out_valid, 0);
      end
      if (j == 2) begin
        chk("first_valid", out_valid, 1);
        chk("first_idx", out_idx, 0);
      end
      if (held) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hd);
        chk("stall_idx", out_idx, hi);
        chk("stall_last", out_last, hl);
      end
      if (done) begin
        dones++;
        chk("done_time", j, 65 + stalls);
      end
      if (!busy) begin
        chk("idle_time", j, 66 + stalls);
        fin = 1'b1;
      end else begin
        if (mode == 1) out_ready = 1'($urandom_range(0, 1));
        held = out_valid && !out_ready;
        if (held) begin
          stalls++;
          hd = out_data; hi = out_idx; hl = out_last;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("extra_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("beat_idx", out_idx, e.idx);
            chk("beat_data", out_data, e.data);
            chk("beat_last", out_last, e.last);
          end
        end
      end
    end
    chk("dump_finished", fin, 1);
    chk("beats_missing", exp_q.size(), 0);
    chk("done_count", dones, 1);
    exp_q.delete();
  endtask

  initial begin
    bit found;
    rst_n = 1'b1; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) gpr[i] = 32'h1000_0000 + i;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_raddr", gpr_raddr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Plain dump with ready held high.
    run_dump(0, 0, 0);

    // Random backpressure on a different data pattern.
    for (int i = 0; i < 32; i++) gpr[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    run_dump(1, 0, 0);

    // Start re-pulsed mid-dump must be ignored.
    for (int i = 0; i < 32; i++) gpr[i] = 32'h1000_0000 + i;
    run_dump(0, 10, 0);
    repeat (4) begin
      @(negedge clk);
      chk("no_requeue_busy", busy, 0);
    end

    // Asynchronous reset while beat 7 is waiting in SEND.
    start = 1'b1; out_ready = 1'b1; found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_idx == 5'd7) begin
        out_ready = 1'b0;
        found = 1'b1;
      end
    end
    chk("reach_idx7", found, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_idx", out_idx, 0);
    chk("arst_last", out_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_raddr", gpr_raddr, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("arst_no_done", done, 0);
    end
    run_dump(0, 0, 0);

    // Consumer never ready: first beat must sit there indefinitely.
    start = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (40) @(negedge clk);
    chk("stuck_valid", out_valid, 1);
    chk("stuck_idx", out_idx, 0);
    chk("stuck_data", out_data, gpr[0]);
    chk("stuck_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back dumps with start held high throughout the first.
    run_dump(0, 0, 1);
    for (int i = 0; i < 32; i++) gpr[i] = 32'hC0DE_0000 + (i << 4);
    run_dump(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_23060191_gpr_dump.md
# ysyx_23060191_gpr_dump

Sequential read-out engine for the general-purpose register file. On a start pulse it walks the register file read port from x0 to x31. It latches each value and streams it to a consumer over a valid/ready handshake, tagged with the register index and a last flag. It sits between the GPR read port and the difftest/debug side, which uses it to compare architectural state after each committed instruction.

## Interface
- NREG, 32, number of registers walked (indices 0..NREG-1); fixed at 32 for RV32E/I use.
- DATA_W, `CPU_WIDTH, register data width.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a full dump; sampled only in IDLE.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse after the last register has been accepted.
- gpr_raddr  out  5  GPR read address; the GPR returns gpr_rdata combinationally in the same cycle.
- gpr_rdata  in  DATA_W  GPR read data.
- out_valid  out  1  out_data/out_idx/out_last hold a valid beat.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready at a rising edge.
- out_data  out  DATA_W  latched register value.
- out_idx  out  5  index of the register in out_data.
- out_last  out  1  high with the beat for index NREG-1.

## Operation
- Internal index counter idx (5 bit); gpr_raddr = idx in every state.
- States:
  - IDLE: start=1 -> FETCH, idx<=0.
  - FETCH: out_data<=gpr_rdata, out_idx<=idx, out_last<=(idx==NREG-1), out_valid<=1 -> SEND.
  - SEND: hold until handshake. On handshake: out_valid<=0. If idx==NREG-1 -> DONE, else idx<=idx+1 -> FETCH.
  - DONE: -> IDLE unconditionally, idx<=0.
- busy = (state!=IDLE); done = (state==DONE). Both are decoded from registered state and are glitch-free.
- start in any state other than IDLE is ignored; it is not queued.
- While out_valid=1, out_data/out_idx/out_last are stable until accepted. out_valid never drops without a handshake, except on reset.
- out_ready may be asserted before out_valid; ready with no valid has no effect.
- Each register value is captured in its own FETCH cycle. The dump is not an atomic snapshot, so the core must be stalled while busy=1.
- x0 is read like any other register; no forcing of zero is done here.
- Reset values: state=IDLE, idx=0, gpr_raddr=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0.
- Reset mid-dump clears everything asynchronously. No done pulse is emitted and the partial dump is abandoned.

## Timing
- Edge E0 samples start=1 in IDLE. At E1 the FSM enters FETCH (busy=1, gpr_raddr=0).
- At E2 out_valid=1 with out_idx=0.
- With out_ready held high, register k is accepted at edge E(2k+3), giving 2 cycles per register.
- Last beat (idx 31, out_last=1) is accepted at E65. done=1 in the cycle after E65; IDLE and busy=0 at E66.
- Each cycle out_ready is low in SEND adds exactly one cycle of latency.
- A new start is accepted at the earliest on the edge at which state is IDLE again (E66 sample -> FETCH at E67).

## Structure
- Add state encodings GD_IDLE/GD_FETCH/GD_SEND/GD_DONE (2 bit) to ysyx_23060191_defines.v. Reuse `CPU_WIDTH and `X0..`X31 from there.
- Single flat module. No sub-module: the FSM, index counter and output register are small enough to sit together.

## Test plan
- Preload gpr[i]=0x1000_0000+i, out_ready=1, pulse start -> 32 beats, out_idx 0..31 in order, out_data matching, out_last only on idx 31, done at the cycle after E65, busy low at E66.
- out_ready toggling 1,0,0,1 pseudo-randomly -> no beat lost or duplicated; data/idx stable while valid&&!ready; total cycles = 66 + number of stalled SEND cycles.
- start re-pulsed at E10 during a dump -> ignored; exactly 32 beats and one done pulse.
- rst_n low asynchronously mid-SEND at idx 7 -> outputs immediately 0, no done pulse; a fresh start then dumps from idx 0.
- out_ready=0 forever after start -> out_valid stays 1 with out_idx=0, out_data=gpr[0], busy=1 indefinitely.
- Two back-to-back dumps with start held high continuously -> second dump begins FETCH at E67, 32 more beats, two done pulses total.
